// File: rtl/uart_tx.sv
// uart_tx: serialises a WIDTH-bit word as start, LSB-first data, optional parity and 1-2 stop bits.
// The line is driven from a register that is loaded on the same edge as each state change.
module uart_tx #(
    parameter int WIDTH    = 8,
    parameter int FCLK     = 50000000,
    parameter int FBAUD    = 115200,
    parameter int PARITY   = 0,
    parameter int STOPBITS = 1
) (
    input  logic             clk50m,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_start,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_idle,
    output logic             tx_done
);
    localparam int BITPER = FCLK / FBAUD;
    localparam int CW     = $clog2(BITPER);
    localparam int BW     = $clog2(WIDTH);
    localparam logic [CW-1:0] RELOAD = CW'(BITPER - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             par_q, par_d;
    logic             stp_q, stp_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             tick;

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE || tick) ? cnt_q : cnt_q - 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        stp_d   = stp_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (tx_start) begin
                sh_d    = tx_data;
                par_d   = (^tx_data) ^ (PARITY == 2);
                cnt_d   = RELOAD;
                state_d = START;
            end
            START: if (tick) begin
                cnt_d   = RELOAD;
                bit_d   = '0;
                state_d = DATA;
            end
            DATA: if (tick) begin
                cnt_d = RELOAD;
                sh_d  = sh_q >> 1;
                bit_d = bit_q + 1'b1;
                if (bit_q == BW'(WIDTH - 1)) begin
                    state_d = (PARITY != 0) ? PAR : STOP;
                    stp_d   = 1'b0;
                end
            end
            PAR: if (tick) begin
                cnt_d   = RELOAD;
                stp_d   = 1'b0;
                state_d = STOP;
            end
            STOP: if (tick) begin
                if (STOPBITS == 2 && !stp_q) begin
                    cnt_d = RELOAD;
                    stp_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Line level follows the state being entered so it changes on the transition edge.
        tx_d = (state_d == START) ? 1'b0 :
               (state_d == DATA)  ? sh_d[0] :
               (state_d == PAR)   ? par_d : 1'b1;
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            stp_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            stp_q   <= stp_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != IDLE);
    assign tx_idle = (state_q == IDLE);
    assign tx_done = done_q;
endmodule
